// File: rtl/oen_out_serializer_pkg.sv
// Shared constants and helpers for the odd-even merge sorter family:
// default geometry, index-width function and emission-order encodings.
package oen_out_serializer_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int N_INPUTS_DEF   = 8;

   localparam logic ORDER_ASC  = 1'b0;
   localparam logic ORDER_DESC = 1'b1;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/oen_out_serializer_if.sv
// Vector-in / element-out handshake bundle for the output serializer.
interface oen_out_serializer_if
   import oen_out_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N_INPUTS   = N_INPUTS_DEF
);
   localparam int IDX_W = clog2(N_INPUTS);

   logic [N_INPUTS*DATA_WIDTH-1:0] in_vec;
   logic                           in_order;
   logic                           in_valid;
   logic                           in_ready;
   logic                           flush;
   logic [DATA_WIDTH-1:0]          out_data;
   logic [IDX_W-1:0]               out_index;
   logic                           out_last;
   logic                           out_valid;
   logic                           out_ready;
   logic                           busy;

   modport slave (
      input  in_vec, in_order, in_valid, flush, out_ready,
      output in_ready, out_data, out_index, out_last, out_valid, busy
   );

   modport master (
      output in_vec, in_order, in_valid, flush, out_ready,
      input  in_ready, out_data, out_index, out_last, out_valid, busy
   );

endinterface

// File: rtl/oen_vec_buffer.sv
// Two-slot ping-pong vector store with full flags, read/write pointers
// and per-slot order bit; presents the head slot to the element mux.
module oen_vec_buffer
   import oen_out_serializer_pkg::*;
#(
   parameter int VEC_W = DATA_WIDTH_DEF * N_INPUTS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [VEC_W-1:0] wr_vec,
   input  logic             wr_order,
   input  logic             pop,
   input  logic             flush,
   output logic [VEC_W-1:0] head_vec,
   output logic             head_order,
   output logic             head_full,
   output logic             in_ready,
   output logic             busy
);

   logic [VEC_W-1:0] slot_vec [2];
   logic [1:0]       slot_order;
   logic [1:0]       full;
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         full       <= '0;
         slot_order <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
      end else if (flush) begin
         full   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         // With one slot full the pointers differ, so pop and write never collide.
         if (pop) begin
            full[rd_ptr] <= 1'b0;
            rd_ptr       <= ~rd_ptr;
         end
         if (wr_en) begin
            full[wr_ptr]       <= 1'b1;
            slot_order[wr_ptr] <= wr_order;
            wr_ptr             <= ~wr_ptr;
         end
      end
   end

   // Payload needs no reset: it is only observed behind a full flag.
   always_ff @(posedge clk) begin
      if (wr_en) slot_vec[wr_ptr] <= wr_vec;
   end

   assign head_vec   = slot_vec[rd_ptr];
   assign head_order = slot_order[rd_ptr];
   assign head_full  = full[rd_ptr] & rst;
   assign in_ready   = ~(full[0] & full[1]) & rst;
   assign busy       = (full[0] | full[1]) & rst;

endmodule

// File: rtl/oen_out_serializer.sv
// Streams buffered sorted vectors one element per cycle, ascending or
// descending per vector, under valid/ready flow control.
module oen_out_serializer
   import oen_out_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N_INPUTS   = N_INPUTS_DEF
) (
   input logic                  clk,
   input logic                  rst,
   oen_out_serializer_if.slave  bus
);

   localparam int IDX_W = clog2(N_INPUTS);
   localparam int VEC_W = N_INPUTS * DATA_WIDTH;

   logic [VEC_W-1:0] head_vec;
   logic             head_order;
   logic             head_full;
   logic             in_ready;
   logic             busy;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             last;
   logic             xfer;

   oen_vec_buffer #(.VEC_W(VEC_W)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (bus.in_valid & in_ready),
      .wr_vec     (bus.in_vec),
      .wr_order   (bus.in_order),
      .pop        (xfer & last),
      .flush      (bus.flush),
      .head_vec   (head_vec),
      .head_order (head_order),
      .head_full  (head_full),
      .in_ready   (in_ready),
      .busy       (busy)
   );

   assign last = (cnt == IDX_W'(N_INPUTS - 1));
   assign xfer = head_full & bus.out_ready;
   // N_INPUTS is a power of two, so N_INPUTS-1-cnt is simply ~cnt.
   assign idx  = (head_order == ORDER_DESC) ? ~cnt : cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (bus.flush) begin
         cnt <= '0;
      end else if (xfer) begin
         cnt <= last ? '0 : cnt + IDX_W'(1);
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy;
   assign bus.out_valid = head_full;
   assign bus.out_data  = head_full ? head_vec[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign bus.out_index = head_full ? idx : '0;
   assign bus.out_last  = head_full & last;

endmodule

// File: tb/tb_oen_out_serializer.sv
// Bench for oen_out_serializer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_oen_out_serializer;
   import oen_out_serializer_pkg::*;

   localparam int DW = 32;
   localparam int N  = 8;
   localparam int IW = 3;

   logic clk;
   logic rst;

   oen_out_serializer_if #(.DATA_WIDTH(DW), .N_INPUTS(N)) bus ();

   oen_out_serializer #(.DATA_WIDTH(DW), .N_INPUTS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: pending vectors in arrival order plus elements already sent from the head.
   logic [N*DW-1:0] mq[$];
   logic            mo[$];
   int              mcnt = 0;

   // Transfer log used by directed checks.
   int got[$];
   int got_cyc[$];
   int got_idx[$];
   int got_last[$];

   always @(negedge clk) begin
      int  idx;
      bit  xfer, acc;
      if (!rst) begin
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data",  bus.out_data,  0);
         chk("rst_out_index", bus.out_index, 0);
         chk("rst_out_last",  bus.out_last,  0);
         chk("rst_busy",      bus.busy,      0);
         chk("rst_in_ready",  bus.in_ready,  0);
         mq.delete(); mo.delete(); mcnt = 0;
      end else begin
         chk("out_valid", bus.out_valid, mq.size() > 0);
         chk("in_ready",  bus.in_ready,  mq.size() < 2);
         chk("busy",      bus.busy,      mq.size() > 0);
         if (mq.size() > 0) begin
            idx = mo[0] ? (N - 1 - mcnt) : mcnt;
            chk("out_data",  bus.out_data,  mq[0][idx*DW +: DW]);
            chk("out_index", bus.out_index, idx);
            chk("out_last",  bus.out_last,  mcnt == N - 1);
         end
         xfer = (mq.size() > 0) && bus.out_ready;
         acc  = bus.in_valid && (mq.size() < 2);
         if (xfer) begin
            got.push_back(int'(bus.out_data));
            got_cyc.push_back(cyc);
            got_idx.push_back(int'(bus.out_index));
            got_last.push_back(int'(bus.out_last));
         end
         if (bus.flush) begin
            mq.delete(); mo.delete(); mcnt = 0;
         end else begin
            if (xfer) begin
               mcnt++;
               if (mcnt == N) begin
                  mcnt = 0;
                  void'(mq.pop_front());
                  void'(mo.pop_front());
               end
            end
            if (acc) begin
               mq.push_back(bus.in_vec);
               mo.push_back(bus.in_order);
            end
         end
      end
   end

   function automatic logic [N*DW-1:0] mk(input int base);
      logic [N*DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one vector until it is accepted; returns the cycle stamp of the accepting edge.
   task automatic send(input logic [N*DW-1:0] v, input logic ord, output int acc_cyc);
      bit seen;
      bus.in_vec   = v;
      bus.in_order = ord;
      bus.in_valid = 1'b1;
      acc_cyc = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         seen = bus.in_ready;
         tick();
         if (seen) begin
            acc_cyc = cyc;
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (acc_cyc < 0) chk("send_timeout", 1, 0);
   endtask

   task automatic wait_got(input int n);
      int t;
      for (t = 0; t < 200 && got.size() < n; t++) tick();
      if (got.size() < n) chk("wait_got_timeout", got.size(), n);
   endtask

   task automatic clear_log();
      got.delete(); got_cyc.delete(); got_idx.delete(); got_last.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   int a_cyc, b_cyc, c_cyc;
   int lastpos;

   initial begin
      rst          = 1'b0;
      bus.in_vec   = '0;
      bus.in_order = 1'b0;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.out_ready = 1'b1;
      do_reset();
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_out_valid", bus.out_valid, 0);
      tick();

      // Single ascending vector.
      clear_log();
      send(mk(0), ORDER_ASC, a_cyc);
      wait_got(8);
      tick();
      chk("asc_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         chk("asc_data",  got[i], i);
         chk("asc_index", got_idx[i], i);
         chk("asc_last",  got_last[i], i == 7);
         chk("asc_cycle", got_cyc[i], a_cyc + i);
      end
      @(negedge clk);
      chk("asc_busy_after", bus.busy, 0);
      tick();

      // Single descending vector.
      clear_log();
      send(mk(0), ORDER_DESC, a_cyc);
      wait_got(8);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         chk("desc_data",  got[i], 7 - i);
         chk("desc_index", got_idx[i], 7 - i);
         chk("desc_last",  got_last[i], i == 7);
      end
      tick(); tick();

      // Back-to-back A, B, then C waits for A's final pop.
      clear_log();
      send(mk(0), ORDER_ASC, a_cyc);
      send(mk(100), ORDER_ASC, b_cyc);
      chk("b2b_b_cycle", b_cyc, a_cyc + 1);
      @(negedge clk);
      chk("b2b_full_in_ready", bus.in_ready, 0);
      tick();
      send(mk(200), ORDER_ASC, c_cyc);
      chk("b2b_c_cycle", c_cyc, a_cyc + 9);
      wait_got(24);
      for (int i = 0; i < 24 && i < got.size(); i++) begin
         chk("b2b_data",  got[i], (i < 8) ? i : (i < 16) ? (100 + i - 8) : (200 + i - 16));
         chk("b2b_cycle", got_cyc[i], a_cyc + i);
      end
      tick(); tick();

      // Backpressure pattern 1,0,0,1,... on an ascending vector.
      clear_log();
      send(mk(50), ORDER_ASC, a_cyc);
      for (int t = 0; t < 40 && got.size() < 8; t++) begin
         bus.out_ready = (t % 3 == 0);
         tick();
      end
      bus.out_ready = 1'b1;
      chk("bp_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_data", got[i], 50 + i);
      tick(); tick();

      // Flush after 3 elements of A with B buffered, then C.
      clear_log();
      send(mk(0), ORDER_ASC, a_cyc);
      send(mk(100), ORDER_ASC, b_cyc);
      wait_got(2);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_in_ready", bus.in_ready, 1);
      chk("flush_busy", bus.busy, 0);
      tick();
      send(mk(300), ORDER_ASC, c_cyc);
      wait_got(11);
      chk("flush_count", got.size(), 11);
      for (int i = 0; i < 11 && i < got.size(); i++)
         chk("flush_data", got[i], (i < 3) ? i : (300 + i - 3));
      tick(); tick();

      // Reset for one cycle mid-stream.
      clear_log();
      send(mk(0), ORDER_DESC, a_cyc);
      wait_got(2);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_after_busy", bus.busy, 0);
      tick();
      send(mk(400), ORDER_ASC, c_cyc);
      wait_got(10);
      chk("midrst_count", got.size(), 10);
      for (int i = 0; i < 10 && i < got.size(); i++)
         chk("midrst_data", got[i], (i < 2) ? (7 - i) : (400 + i - 2));
      tick(); tick();

      // Random traffic against the model.
      for (int t = 0; t < 4000; t++) begin
         for (int k = 0; k < N; k++) bus.in_vec[k*DW +: DW] = $urandom;
         bus.in_order  = $urandom_range(0, 1) == 1;
         bus.in_valid  = $urandom_range(0, 2) != 0;
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.flush     = $urandom_range(0, 59) == 0;
         rst           = $urandom_range(0, 199) != 0;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      for (int t = 0; t < 20; t++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
